// File: rtl/axi_lite_slave.sv
// AXI4-Lite slave with a NUM_REGS x 32-bit register file and independent read/write FSMs.
// Define AXIL_SLAVE_WSTRB_EN to honour per-byte write strobes; otherwise writes replace the full word.
module axi_lite_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                      aclk,
    input  logic                      areset_n,

    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,

    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,

    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,

    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,

    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int IDX_W     = ADDR_WIDTH - 2;
    localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int LANES     = DATA_WIDTH / 8;

    localparam logic [IDX_W:0] NUM_REGS_W  = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACK,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACK,
        R_DATA
    } r_state_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]     aw_idx;
    logic [IDX_W-1:0]     ar_idx;
    logic [REG_IDX_W-1:0] aw_sel;
    logic [REG_IDX_W-1:0] ar_sel;
    logic                 aw_hit;
    logic                 ar_hit;

    assign aw_idx = awaddr[ADDR_WIDTH-1:2];
    assign ar_idx = araddr[ADDR_WIDTH-1:2];
    assign aw_sel = aw_idx[REG_IDX_W-1:0];
    assign ar_sel = ar_idx[REG_IDX_W-1:0];
    assign aw_hit = {1'b0, aw_idx} < NUM_REGS_W;
    assign ar_hit = {1'b0, ar_idx} < NUM_REGS_W;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] wr_word;
    logic                  wr_en;
    w_state_e              w_state_q;
    w_state_e              w_state_d;

    assign wr_en = (w_state_q == W_ACK) && aw_hit;

`ifdef AXIL_SLAVE_WSTRB_EN
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_word = regs_q[aw_sel];
        for (int b = 0; b < LANES; b++) begin
            if (wstrb[b]) begin
                wr_word[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    logic [3:0] unused_addr_lsbs;
    assign unused_addr_lsbs = {awaddr[1:0], araddr[1:0]};
`else
    always_comb begin
        wr_word = wdata;
    end

    logic [LANES+3:0] unused_addr_lsbs;
    assign unused_addr_lsbs = {wstrb, awaddr[1:0], araddr[1:0]};
`endif

    // NOTE: the register file is reset because software-visible contents must read 0 after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[aw_sel] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    logic       awready_q, awready_d;
    logic       wready_q,  wready_d;
    logic       bvalid_q,  bvalid_d;
    logic [1:0] bresp_q,   bresp_d;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (awvalid && wvalid) w_state_d = W_ACK;
            W_ACK:   w_state_d = W_RESP;
            W_RESP:  if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // AW and W are accepted together; a lone channel waits unacknowledged.
    always_comb begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && wvalid) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            W_ACK: begin
                bvalid_d = 1'b1;
                bresp_d  = aw_hit ? RESP_OKAY : RESP_SLVERR;
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                end
            end
            default: begin
                bvalid_d = 1'b0;
            end
        endcase
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (arvalid) r_state_d = R_ACK;
            R_ACK:   r_state_d = R_DATA;
            R_DATA:  if (rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // The capture reads regs_q before a same-cycle write lands, so a collision returns the old value.
    always_comb begin
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    arready_d = 1'b1;
                end
            end
            R_ACK: begin
                rvalid_d = 1'b1;
                rresp_d  = ar_hit ? RESP_OKAY : RESP_SLVERR;
                rdata_d  = ar_hit ? regs_q[ar_sel] : '0;
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                rvalid_d = 1'b0;
            end
        endcase
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Scoreboard bench for axi_lite_slave: stimulus pushes expected responses, a monitor pops them on each handshake.
// The reference model is a plain word array honouring AXIL_SLAVE_WSTRB_EN when it is defined.
module tb_axi_lite_slave;

    localparam int AW = 8;
    localparam int NR = 16;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 aclk = ~aclk;

    axi_lite_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [31:0] ref_mem [NR];
    logic [1:0]  exp_b [$];
    rexp_t       exp_r [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit in_range(input logic [7:0] a);
        return int'(a[7:2]) < NR;
    endfunction

    function automatic logic [1:0] resp_of(input logic [7:0] a);
        return in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        return in_range(a) ? ref_mem[int'(a[7:2])] : 32'h0;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] word;
        if (!in_range(a)) return;
`ifdef AXIL_SLAVE_WSTRB_EN
        word = ref_mem[int'(a[7:2])];
        for (int b = 0; b < 4; b++) begin
            if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        end
`else
        word = d;
        if (s == 4'hx) word = 'x;
`endif
        ref_mem[int'(a[7:2])] = word;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) ref_mem[i] = 32'h0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge aclk) begin
        logic [1:0] eb;
        rexp_t      er;
        if (areset_n && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected", 32'(bvalid), 32'h0);
            end else begin
                eb = exp_b.pop_front();
                check("bresp", 32'(bresp), 32'(eb));
            end
        end
        if (areset_n && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                check("r_unexpected", 32'(rvalid), 32'h0);
            end else begin
                er = exp_r.pop_front();
                check("rresp", 32'(rresp), 32'(er.resp));
                check("rdata", rdata, er.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr_issue(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        exp_b.push_back(resp_of(a));
        model_write(a, d, s);
    endtask

    task automatic rd_issue(input logic [7:0] a, input rexp_t e);
        araddr  = a;
        arvalid = 1'b1;
        exp_r.push_back(e);
    endtask

    task automatic wr_finish(input int bp, input logic [1:0] resp);
        int n;
        for (n = 1; n <= 8; n++) begin
            @(negedge aclk);
            if (awready) break;
        end
        check("awready_latency", 32'(n), 32'd2);
        check("wready_with_awready", 32'(wready), 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge aclk);
        check("bvalid_latency", 32'(bvalid), 32'd1);
        check("awready_one_cycle", 32'(awready), 32'd0);
        for (int i = 0; i < bp; i++) begin
            @(negedge aclk);
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("bresp_hold", 32'(bresp), 32'(resp));
        end
        @(posedge aclk); #1;
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        check("bvalid_clear", 32'(bvalid), 32'd0);
    endtask

    task automatic rd_finish(input int bp, input rexp_t e);
        int n;
        for (n = 1; n <= 8; n++) begin
            @(negedge aclk);
            if (arready) break;
        end
        check("arready_latency", 32'(n), 32'd2);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        check("rvalid_latency", 32'(rvalid), 32'd1);
        check("arready_one_cycle", 32'(arready), 32'd0);
        for (int i = 0; i < bp; i++) begin
            @(negedge aclk);
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, e.data);
            check("rresp_hold", 32'(rresp), 32'(e.resp));
        end
        @(posedge aclk); #1;
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        @(negedge aclk);
        check("rvalid_clear", 32'(rvalid), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int bp);
        @(posedge aclk); #1;
        wr_issue(a, d, s);
        wr_finish(bp, resp_of(a));
    endtask

    task automatic do_read(input logic [7:0] a, input int bp);
        rexp_t e;
        @(posedge aclk); #1;
        e.data = model_read(a);
        e.resp = resp_of(a);
        rd_issue(a, e);
        rd_finish(bp, e);
    endtask

    // Read expectation is taken before the model write: a colliding read sees the old value.
    task automatic do_concurrent(input logic [7:0] wa, input logic [31:0] d, input logic [3:0] s,
                                 input logic [7:0] ra, input int bp);
        rexp_t e;
        @(posedge aclk); #1;
        e.data = model_read(ra);
        e.resp = resp_of(ra);
        rd_issue(ra, e);
        wr_issue(wa, d, s);
        fork
            wr_finish(bp, resp_of(wa));
            rd_finish(bp, e);
        join
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_rdata",   rdata,        32'd0);
        @(posedge aclk); #1;
        areset_n = 1'b1;

        // Write then read
        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0);
        do_read(8'h04, 0);

        // Out of range, and a lone AW without W is not acknowledged
        do_write(8'h40, 32'h12345678, 4'hF, 0);
        do_read(8'h40, 0);
        do_read(8'h00, 0);
        @(posedge aclk); #1;
        awaddr  = 8'h00;
        awvalid = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check("aw_alone_no_ready", 32'(awready), 32'd0);
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;

        // Byte strobes (model applies or ignores them according to the build)
        do_write(8'h08, 32'h11223344, 4'hF, 0);
        do_write(8'h09, 32'hAABBCCDD, 4'b0101, 0);
        do_read(8'h0B, 0);
`ifdef AXIL_SLAVE_WSTRB_EN
        check("strobe_model", ref_mem[2], 32'h11BB33DD);
`else
        check("strobe_model", ref_mem[2], 32'hAABBCCDD);
`endif

        // Back-pressure
        do_write(8'h0C, 32'hCAFEF00D, 4'hF, 5);
        do_read(8'h0C, 5);

        // Same-register collision
        do_write(8'h14, 32'h3, 4'hF, 0);
        do_concurrent(8'h14, 32'h5, 4'hF, 8'h14, 0);
        do_read(8'h14, 0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [7:0]  a;
            logic [7:0]  ra;
            logic [31:0] d;
            logic [3:0]  s;
            int          bp;
            op = $urandom_range(0, 2);
            a  = 8'($urandom_range(0, 8'h4F));
            ra = 8'($urandom_range(0, 8'h4F));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            bp = $urandom_range(0, 3);
            case (op)
                0:       do_write(a, d, s, bp);
                1:       do_read(a, bp);
                default: do_concurrent(a, d, s, ra, bp);
            endcase
        end

        // Reset while the write response is pending
        do_write(8'h10, 32'hFFFF0000, 4'hF, 0);
        @(posedge aclk); #1;
        wr_issue(8'h10, 32'h0BADF00D, 4'hF);
        for (n = 1; n <= 8; n++) begin
            @(negedge aclk);
            if (awready) break;
        end
        check("mid_awready_latency", 32'(n), 32'd2);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge aclk);
        check("mid_bvalid_pending", 32'(bvalid), 32'd1);
        #2;
        areset_n = 1'b0;
        #1;
        check("mid_rst_bvalid_immediate", 32'(bvalid), 32'd0);
        void'(exp_b.pop_back());
        model_reset();
        @(posedge aclk); #1;
        areset_n = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check("mid_rst_no_bvalid", 32'(bvalid), 32'd0);
        end
        for (int r = 0; r < NR; r++) begin
            do_read(8'(r * 4), 0);
        end

        repeat (2) @(posedge aclk);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
